// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a show-ahead FIFO and sends start,
// DBIT data bits (LSB first) and stop, timed by a 16x oversampling s_tick.
module fifo_uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [4:0] TICK_LAST = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

    logic [1:0]      state_q, state_d;
    logic [4:0]      s_cnt_q, s_cnt_d;
    logic [2:0]      n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_reg_q, b_reg_d;
    logic            tx_q, tx_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        n_cnt_d      = n_cnt_q;
        b_reg_d      = b_reg_q;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        tx_d         = 1'b1;
        case (state_q)
            IDLE: begin
                // The pop cycle captures the head word; a tick here is not counted.
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    b_reg_d = fifo_r_data;
                    s_cnt_d = 5'd0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_cnt_q == TICK_LAST) begin
                        s_cnt_d = 5'd0;
                        n_cnt_d = 3'd0;
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                tx_d = b_reg_q[0];
                if (s_tick) begin
                    if (s_cnt_q == TICK_LAST) begin
                        s_cnt_d = 5'd0;
                        b_reg_d = b_reg_q >> 1;
                        if (n_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset dominates the strobes so no word is popped or reported while held.
        if (reset) begin
            fifo_rd      = 1'b0;
            tx_done_tick = 1'b0;
        end
    end

    assign tx_busy = (state_q != IDLE) && !reset;
    assign tx      = tx_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_cnt_q <= 5'd0;
            n_cnt_q <= 3'd0;
            b_reg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_reg_q <= b_reg_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations share reset and s_tick, each
// fed from its own FIFO and checked every clk against a tick-count frame model.
module tb_fifo_uart_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic [2:0] fifo_empty_v;
    logic [2:0] rd_v, tx_v, busy_v, done_v;
    logic [7:0] head [3];

    always #5 clk = ~clk;

    fifo_uart_tx #(.DBIT(8), .SB_TICK(16)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty_v[0]),
        .fifo_r_data(head[0]), .fifo_rd(rd_v[0]), .tx(tx_v[0]),
        .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]));

    fifo_uart_tx #(.DBIT(8), .SB_TICK(32)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty_v[1]),
        .fifo_r_data(head[1]), .fifo_rd(rd_v[1]), .tx(tx_v[1]),
        .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]));

    fifo_uart_tx #(.DBIT(5), .SB_TICK(24)) dut2 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty_v[2]),
        .fifo_r_data(head[2][4:0]), .fifo_rd(rd_v[2]), .tx(tx_v[2]),
        .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]));

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   tick_mode = 0;
    logic rst_cmd  = 1'b1;
    bit   tx_known = 1'b0;

    // Reference model: a frame is just a count of s_ticks since the pop.
    bit         m_busy [3];
    int         m_cnt  [3];
    logic [7:0] m_word [3];
    logic       m_tx   [3];

    logic [7:0] fifo_mem [3][64];
    int         rd_ptr [3];
    int         wr_ptr [3];

    int pops [3];
    int dones [3];
    bit in_fr [3];
    int meas [3];
    int last_done_cyc = -100000;
    int b2b_gap = -1;

    function automatic int dbit_of(input int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic int sb_of(input int i);
        case (i)
            0:       return 16;
            1:       return 32;
            default: return 24;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        for (int i = 0; i < 3; i++) begin
            fifo_mem[i][wr_ptr[i] % 64] = b;
            wr_ptr[i]++;
        end
    endtask

    function automatic bit all_idle();
        bit r = 1'b1;
        for (int i = 0; i < 3; i++)
            if (m_busy[i] || rd_ptr[i] != wr_ptr[i]) r = 1'b0;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        case (tick_mode)
            0:       s_tick = (cyc % 4 == 0);
            1:       s_tick = ($urandom_range(0, 2) == 0);
            default: s_tick = cyc[0];
        endcase
        reset = rst_cmd;
        for (int i = 0; i < 3; i++) begin
            fifo_empty_v[i] = (rd_ptr[i] == wr_ptr[i]);
            head[i] = fifo_empty_v[i] ? 8'($urandom) : fifo_mem[i][rd_ptr[i] % 64];
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            int   flen;
            int   bi;
            logic e_rd, e_busy, e_done, line;
            flen   = 16 + 16 * dbit_of(i) + sb_of(i);
            e_rd   = !reset && !m_busy[i] && !fifo_empty_v[i];
            e_busy = !reset && m_busy[i];
            e_done = !reset && m_busy[i] && s_tick && (m_cnt[i] == flen - 1);
            check($sformatf("fifo_rd[%0d]", i), rd_v[i], e_rd);
            check($sformatf("tx_busy[%0d]", i), busy_v[i], e_busy);
            check($sformatf("tx_done_tick[%0d]", i), done_v[i], e_done);
            if (tx_known) check($sformatf("tx[%0d]", i), tx_v[i], m_tx[i]);

            if (!m_busy[i]) line = 1'b1;
            else if (m_cnt[i] < 16) line = 1'b0;
            else if (m_cnt[i] < 16 + 16 * dbit_of(i)) begin
                bi   = (m_cnt[i] - 16) / 16;
                line = m_word[i][bi];
            end else line = 1'b1;

            // Observed frame length in s_ticks, pop cycle excluded, done cycle included.
            if (rd_v[i]) pops[i]++;
            if (done_v[i]) dones[i]++;
            if (reset) in_fr[i] = 1'b0;
            else if (rd_v[i]) begin
                in_fr[i] = 1'b1;
                meas[i]  = 0;
            end else if (in_fr[i] && s_tick) meas[i]++;
            if (done_v[i] && in_fr[i]) begin
                check($sformatf("frame_len[%0d]", i), meas[i], flen);
                in_fr[i] = 1'b0;
            end
            if (i == 0) begin
                if (done_v[0]) last_done_cyc = cyc;
                if (rd_v[0]) b2b_gap = cyc - last_done_cyc;
            end

            if (reset) begin
                m_busy[i] = 1'b0;
                m_cnt[i]  = 0;
                m_tx[i]   = 1'b1;
            end else begin
                m_tx[i] = line;
                if (e_rd) begin
                    m_busy[i] = 1'b1;
                    m_cnt[i]  = 0;
                    m_word[i] = head[i];
                    rd_ptr[i]++;
                end else if (m_busy[i] && s_tick) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == flen) m_busy[i] = 1'b0;
                end
            end
        end
        if (reset) tx_known = 1'b1;
        @(posedge clk);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check("idle_within_budget", all_idle(), 1);
    endtask

    initial begin
        int p0, d0, n;
        reset        = 1'b1;
        s_tick       = 1'b0;
        fifo_empty_v = '1;
        for (int i = 0; i < 3; i++) begin
            head[i]   = 8'h00;
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
            m_word[i] = 8'h00;
            m_tx[i]   = 1'b1;
            rd_ptr[i] = 0;
            wr_ptr[i] = 0;
            pops[i]   = 0;
            dones[i]  = 0;
            in_fr[i]  = 1'b0;
            meas[i]   = 0;
        end

        // Reset held with a word waiting: nothing may be popped.
        push(8'hA5);
        rst_cmd   = 1'b1;
        tick_mode = 0;
        repeat (3) step();
        check("reset_pops", pops[0] + pops[1] + pops[2], 0);

        // Single 0xA5 frame, s_tick every 4 clks.
        rst_cmd = 1'b0;
        p0 = pops[0];
        d0 = dones[0];
        run_until_idle(4000);
        check("a5_pops", pops[0] - p0, 1);
        check("a5_dones", dones[0] - d0, 1);

        // Back-to-back 0x00 then 0xFF: second pop on the clk after done.
        p0 = pops[0];
        last_done_cyc = -100000;
        b2b_gap = -1;
        push(8'h00);
        push(8'hFF);
        run_until_idle(8000);
        check("b2b_pops", pops[0] - p0, 2);
        check("b2b_gap", b2b_gap, 1);

        // Reset in the middle of data bit 3 of 0x55; 0x96 follows normally.
        p0 = pops[0];
        d0 = dones[0];
        push(8'h55);
        push(8'h96);
        n = 0;
        while (!(m_busy[0] && m_cnt[0] == 16 + 16 * 3 + 8) && n < 4000) begin
            step();
            n++;
        end
        #1;
        check("mid_busy_before_reset", busy_v[0], 1);
        rst_cmd = 1'b1;
        step();
        rst_cmd = 1'b0;
        #1;
        check("mid_tx_after_reset", tx_v[0], 1);
        run_until_idle(8000);
        check("mid_pops", pops[0] - p0, 2);
        check("mid_dones", dones[0] - d0, 1);

        // Randomised data and irregular s_tick.
        tick_mode = 1;
        repeat (3) begin
            repeat (4) push(8'($urandom_range(0, 255)));
            run_until_idle(12000);
        end

        // Empty FIFO with s_tick toggling every clk.
        tick_mode = 2;
        p0 = pops[0] + pops[1] + pops[2];
        repeat (100) step();
        #1;
        check("idle_pops", pops[0] + pops[1] + pops[2] - p0, 0);
        check("idle_tx", tx_v, 3'b111);
        check("idle_busy", busy_v, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame; legal range 5..8.
REQ-002 Parameter SB_TICK, default 16, s_tick count for the stop bit; legal values 16 (1 stop), 24 (1.5 stop), 32 (2 stop).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_tick  input  1  baud oversampling strobe, one clk wide, 16 per bit period.
REQ-006 fifo_empty  input  1  source FIFO empty flag; when low, fifo_r_data holds the head word.
REQ-007 fifo_r_data  input  DBIT  head word of the source FIFO (show-ahead).
REQ-008 fifo_rd  output  1  pop strobe to the source FIFO, one clk wide per consumed word.
REQ-009 tx  output  1  serial line, idle high, registered.
REQ-010 tx_busy  output  1  high while a frame is in progress (FSM not in IDLE).
REQ-011 tx_done_tick  output  1  one-clk pulse at end of stop bit.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; counters: s_cnt (5 bits, tick count), n_cnt (3 bits, bit index), shift register b_reg (DBIT bits).
REQ-013 IDLE: when fifo_empty is low, in that same cycle fifo_rd SHALL be 1, b_reg SHALL load fifo_r_data, s_cnt SHALL clear, and the next state SHALL be START; otherwise the FSM stays in IDLE with fifo_rd 0.
REQ-014 fifo_rd SHALL be asserted only in IDLE with fifo_empty low, never for more than one consecutive clk per word.
REQ-015 START: line value 0; on each s_tick, s_cnt increments; on the s_tick where s_cnt==15, s_cnt and n_cnt clear and the next state is DATA.
REQ-016 DATA: line value b_reg[0] (LSB first); on the s_tick where s_cnt==15, s_cnt clears, b_reg shifts right one bit, and either n_cnt increments or, if n_cnt==DBIT-1, the next state is STOP.
REQ-017 STOP: line value 1; on the s_tick where s_cnt==SB_TICK-1, tx_done_tick SHALL pulse for that clk and the next state is IDLE.
REQ-018 Clocks without s_tick SHALL NOT change s_cnt, n_cnt, b_reg or state outside IDLE.
REQ-019 tx SHALL be a register loaded every clk with the current-state line value, so tx lags the FSM state by exactly one clk.
REQ-020 Frame length SHALL be exactly 16 + 16*DBIT + SB_TICK s_ticks from START entry to IDLE re-entry.
REQ-021 Back-to-back: with the FIFO non-empty at STOP exit, the next pop SHALL occur in the first IDLE clk (one clk gap, no extra idle bit time).
REQ-022 fifo_r_data changes after the pop SHALL NOT affect the frame in progress; only b_reg drives tx.
REQ-023 s_tick in IDLE SHALL be ignored; s_tick in the same clk as the IDLE pop SHALL NOT be counted.
REQ-024 tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-025 With reset high at a clk edge: state IDLE, s_cnt 0, n_cnt 0, b_reg 0, tx 1, and fifo_rd, tx_busy, tx_done_tick 0 combinationally from IDLE with reset priority.
REQ-026 While reset is high, fifo_rd SHALL be 0 regardless of fifo_empty.
REQ-027 Reset mid-frame SHALL abort the frame; the word is discarded (not re-read), and tx is 1 from the clk after reset is sampled.

Verification
REQ-028 Reset held 3 clks with fifo_empty=0 -> fifo_rd stays 0, tx=1, tx_busy=0 throughout.
REQ-029 FIFO holds 0xA5, DBIT=8, SB_TICK=16, s_tick every 4 clks -> one fifo_rd pulse; tx sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 16 s_ticks; one tx_done_tick.
REQ-030 FIFO holds 0x00 then 0xFF back-to-back -> two fifo_rd pulses; the second pulse falls on the clk after tx_done_tick; tx stays high exactly 1 clk between frames.
REQ-031 SB_TICK=32, byte 0x3C -> stop bit lasts 32 s_ticks; total frame is 176 s_ticks.
REQ-032 Reset asserted during DATA bit 3 of 0x55 -> tx=1 the next clk, no tx_done_tick, no extra fifo_rd; the next queued byte transmits normally afterwards.
REQ-033 fifo_empty=1 for 100 clks with s_tick toggling -> tx=1, fifo_rd=0, tx_busy=0 throughout.
